// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU.
//   cmd_t    : 4-bit command (opcode) type, independent of the datapath width
//   OP_*     : opcode constants; 12..15 are reserved and produce a zero result
//   state_t  : control FSM state (IDLE accepts requests, MUL runs the multiplier)
// ----------------------------------------------------------------------------
package alu_pkg;

  typedef logic [3:0] cmd_t;

  localparam cmd_t OP_ADD  = 4'd0;
  localparam cmd_t OP_SUB  = 4'd1;
  localparam cmd_t OP_XOR  = 4'd2;
  localparam cmd_t OP_SLT  = 4'd3;
  localparam cmd_t OP_AND  = 4'd4;
  localparam cmd_t OP_NAND = 4'd5;
  localparam cmd_t OP_NOR  = 4'd6;
  localparam cmd_t OP_OR   = 4'd7;
  localparam cmd_t OP_MUL  = 4'd8;
  localparam cmd_t OP_SLL  = 4'd9;
  localparam cmd_t OP_SRL  = 4'd10;
  localparam cmd_t OP_SRA  = 4'd11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/seq_alu_mul.sv
// ----------------------------------------------------------------------------
// seq_alu_mul
// Unsigned shift-add multiplier, one partial-product iteration per clock.
// The start cycle itself performs iteration 0, so a WIDTH-bit multiply takes
// WIDTH clock edges from start to done (start edge included).
//
// Ports
//   clk_i      : clock, rising edge
//   rst_i      : asynchronous active-high reset, clears all working registers
//   start_i    : begin a multiply with a_i/b_i (only when not busy)
//   a_i, b_i   : unsigned operands, sampled on the start edge only
//   done_o     : high during the cycle whose rising edge completes the last
//                iteration; product_o is valid in that same cycle
//   product_o  : full 2*WIDTH-bit product (meaningful only while done_o=1)
// ----------------------------------------------------------------------------
module seq_alu_mul #(
  parameter int WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;

  // Operands of the current iteration: fresh inputs on the start cycle,
  // working registers otherwise.
  logic [2*WIDTH-1:0] step_acc_in, step_mcand_in, step_acc;
  logic [WIDTH-1:0]   step_mplier_in;

  always_comb begin
    if (start_i) begin
      step_acc_in    = '0;
      step_mcand_in  = {{WIDTH{1'b0}}, a_i};
      step_mplier_in = b_i;
    end else begin
      step_acc_in    = acc_q;
      step_mcand_in  = mcand_q;
      step_mplier_in = mplier_q;
    end
    step_acc = step_acc_in + (step_mplier_in[0] ? step_mcand_in : '0);
  end

  assign done_o    = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign product_o = step_acc;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start_i || busy_q) begin
      acc_d    = step_acc;
      mcand_d  = step_mcand_in << 1;
      mplier_d = step_mplier_in >> 1;
      cnt_d    = start_i ? CW'(1) : cnt_q + CW'(1);
      busy_d   = start_i ? 1'b1 : !done_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// ----------------------------------------------------------------------------
// seq_alu
// Registered ALU with a valid/ready request port and a valid/ready result
// port. Single-cycle operations register their result on the accept edge;
// MUL runs the iterative multiplier and returns WIDTH cycles after accept.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Requests are accepted only in IDLE and only when the result
// register is empty or being drained on the same edge. result/flags hold
// while out_valid=1 and out_ready=0.
//
// Ports
//   clk, reset             : clock (rising edge), async active-high reset
//   in_valid / in_ready    : request handshake
//   command                : opcode (see alu_pkg)
//   operandA, operandB     : WIDTH-bit operands
//   out_valid / out_ready  : result handshake
//   result                 : registered WIDTH-bit result
//   carryout, zero, overflow : registered flags
//   dbg_state_o            : current control FSM state
// ----------------------------------------------------------------------------
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  cmd_t             command,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             zero,
  output logic             overflow,
  output state_t           dbg_state_o
);

  localparam int SW = $clog2(WIDTH);

  state_t state_q, state_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic               accept, mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic [WIDTH:0]   add_ext, sub_ext;
  logic [SW-1:0]    shamt;

  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (command == OP_MUL);

  // ---------------------------------------------------------------- multiplier
  seq_alu_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk_i     (clk),
    .rst_i     (reset),
    .start_i   (mul_start),
    .a_i       (operandA),
    .b_i       (operandB),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  // ------------------------------------------------------ single-cycle datapath
  assign add_ext = {1'b0, operandA} + {1'b0, operandB};
  // A + ~B + 1: the carry out of the MSB is 1 exactly when no borrow occurs.
  assign sub_ext = {1'b0, operandA} + {1'b0, ~operandB} + {{WIDTH{1'b0}}, 1'b1};
  assign shamt   = operandB[SW-1:0];

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (command)
      OP_ADD: begin
        alu_res = add_ext[WIDTH-1:0];
        alu_c   = add_ext[WIDTH];
        alu_v   = (operandA[WIDTH-1] == operandB[WIDTH-1]) &&
                  (add_ext[WIDTH-1] != operandA[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_ext[WIDTH-1:0];
        alu_c   = sub_ext[WIDTH];
        alu_v   = (operandA[WIDTH-1] != operandB[WIDTH-1]) &&
                  (sub_ext[WIDTH-1] != operandA[WIDTH-1]);
      end
      OP_XOR:  alu_res = operandA ^ operandB;
      // Direct signed compare, so the result is right even when A-B overflows.
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(operandA) < $signed(operandB))};
      OP_AND:  alu_res = operandA & operandB;
      OP_NAND: alu_res = ~(operandA & operandB);
      OP_NOR:  alu_res = ~(operandA | operandB);
      OP_OR:   alu_res = operandA | operandB;
      OP_SLL:  alu_res = operandA << shamt;
      OP_SRL:  alu_res = operandA >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(operandA) >>> shamt);
      // MUL goes through the multiplier; reserved opcodes yield all zeros.
      default: begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
      end
    endcase
  end

  // ------------------------------------------------------------ FSM: register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------- FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mul_start) state_d = ST_MUL;
      ST_MUL:  if (mul_done)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------- FSM: outputs
  always_comb begin
    in_ready    = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    dbg_state_o = state_q;
  end

  // ---------------------------------------------------------- result register
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (accept && (command != OP_MUL)) begin
      result_d    = alu_res;
      carry_d     = alu_c;
      ovf_d       = alu_v;
      zero_d      = (alu_res == '0);
      out_valid_d = 1'b1;
    end else if ((state_q == ST_MUL) && mul_done) begin
      result_d    = mul_product[WIDTH-1:0];
      carry_d     = |mul_product[2*WIDTH-1:WIDTH];
      ovf_d       = 1'b0;
      zero_d      = (mul_product[WIDTH-1:0] == '0);
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carryout  = carry_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_seq_alu.sv
// ----------------------------------------------------------------------------
// tb_seq_alu
// Bench for seq_alu: a WIDTH=32 instance checked every cycle against a
// behavioural model with a scoreboard queue, plus a WIDTH=8 instance used
// for the 8-bit multiply latency case.
// ----------------------------------------------------------------------------
module tb_seq_alu;
  import alu_pkg::*;

  localparam int W = 32;

  // ------------------------------------------------------------ clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // ------------------------------------------------------------- DUT (W=32)
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   command;
  logic [W-1:0] operand_a, operand_b, result;
  logic         carryout, zero, overflow;
  state_t       dbg_state;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .command(command),
    .operandA(operand_a), .operandB(operand_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carryout(carryout), .zero(zero), .overflow(overflow),
    .dbg_state_o(dbg_state)
  );

  // -------------------------------------------------------------- DUT (W=8)
  logic       in_valid8, in_ready8, out_valid8, out_ready8;
  logic [3:0] command8;
  logic [7:0] a8, b8, result8;
  logic       carry8, zero8, ovf8;
  state_t     dbg_state8;

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid8), .in_ready(in_ready8), .command(command8),
    .operandA(a8), .operandB(b8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .carryout(carry8), .zero(zero8), .overflow(ovf8),
    .dbg_state_o(dbg_state8)
  );

  // ----------------------------------------------------------------- checking
  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         v;
  } exp_t;

  // Reference model: plain 64-bit arithmetic on the operand values.
  function automatic exp_t model(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t            e;
    longint          sa, sb, sr;
    longint unsigned ua, ub, p;
    int              sh;
    e  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    sh = int'(b[4:0]);
    sr = 0;
    case (cmd)
      4'd0: begin
        e.res = a + b;
        e.c   = ((ua + ub) >> 32) != 64'd0;
        sr    = sa + sb;
        e.v   = (sr != longint'($signed(e.res)));
      end
      4'd1: begin
        e.res = a - b;
        e.c   = (a >= b);
        sr    = sa - sb;
        e.v   = (sr != longint'($signed(e.res)));
      end
      4'd2:  e.res = a ^ b;
      4'd3:  e.res = (sa < sb) ? 32'd1 : 32'd0;
      4'd4:  e.res = a & b;
      4'd5:  e.res = ~(a & b);
      4'd6:  e.res = ~(a | b);
      4'd7:  e.res = a | b;
      4'd8: begin
        p     = ua * ub;
        e.res = p[31:0];
        e.c   = (p[63:32] != 32'd0);
      end
      4'd9:  e.res = a << sh;
      4'd10: e.res = a >> sh;
      4'd11: e.res = W'(sa >>> sh);
      default: e.res = '0;
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  // Scoreboard: expected results and the monitor cycle each becomes visible.
  exp_t exp_q[$];
  int   due_q[$];
  int   cyc      = 0;
  logic m_accept = 1'b0;

  // Compare process: inputs change on the falling edge, everything is read
  // 2ns later, i.e. the values the next rising edge will see.
  initial begin
    logic exp_ov, exp_ir;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_flags", {carryout, zero, overflow}, 0);
        exp_q.delete();
        due_q.delete();
        m_accept = 1'b0;
      end else begin
        exp_ov = (exp_q.size() > 0) && (cyc >= due_q[0]);
        exp_ir = (exp_q.size() == 0) || (exp_ov && out_ready);
        check("out_valid", out_valid, exp_ov);
        check("in_ready", in_ready, exp_ir);
        if (exp_ov) begin
          check("result", result, exp_q[0].res);
          check("carryout", carryout, exp_q[0].c);
          check("zero", zero, exp_q[0].z);
          check("overflow", overflow, exp_q[0].v);
        end
        m_accept = in_valid && exp_ir;
        if (exp_ov && out_ready) begin
          void'(exp_q.pop_front());
          void'(due_q.pop_front());
        end
        if (m_accept) begin
          exp_q.push_back(model(command, operand_a, operand_b));
          due_q.push_back(cyc + ((command == 4'd8) ? W : 1));
        end
      end
      cyc++;
    end
  end

  // ------------------------------------------------------------ driver tasks
  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid  = 1'b0;
      command   = 4'($urandom);
      operand_a = $urandom;
      operand_b = $urandom;
      out_ready = 1'b1;
    end
  endtask

  // Present a request until the model says it is taken on the next edge.
  task automatic send(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b);
    bit taken = 0;
    for (int t = 0; t < 200 && !taken; t++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      command   = cmd;
      operand_a = a;
      operand_b = b;
      out_ready = 1'b1;
      #3;
      taken = m_accept;
    end
    if (!taken) check("send_timeout", 0, 1);
  endtask

  // Single-cycle op with a literal expectation read one cycle after accept.
  task automatic pin(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] er, input logic ec, input logic ez, input logic ev);
    send(cmd, a, b);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #2;
    check("pin_valid", out_valid, 1);
    check("pin_value", {result, carryout, zero, overflow}, {er, ec, ez, ev});
  endtask

  // ---------------------------------------------------------------- stimulus
  int pat[3] = '{1, 0, 1};

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    command    = 4'd0;
    operand_a  = '0;
    operand_b  = '0;
    out_ready  = 1'b1;
    in_valid8  = 1'b0;
    command8   = 4'd0;
    a8         = '0;
    b8         = '0;
    out_ready8 = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Model pinned to hand-computed values.
    check("model_add_ovf", model(4'd0, 32'h7FFF_FFFF, 32'd1), {32'h8000_0000, 1'b0, 1'b0, 1'b1});
    check("model_sub_eq",  model(4'd1, 32'd5, 32'd5),         {32'd0, 1'b1, 1'b1, 1'b0});
    check("model_sub_brw", model(4'd1, 32'd0, 32'd1),         {32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0});
    check("model_slt",     model(4'd3, 32'h8000_0000, 32'd1), {32'd1, 1'b0, 1'b0, 1'b0});
    check("model_sra",     model(4'd11, 32'h8000_0000, 32'd31), {32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0});
    check("model_rsv",     model(4'd13, 32'h1234, 32'h5678),  {32'd0, 1'b0, 1'b1, 1'b0});
    check("model_mul_hi",  model(4'd8, 32'h1_0000, 32'h1_0000), {32'd0, 1'b1, 1'b1, 1'b0});

    // 8-bit multiply: 0x10 * 0x11 = 0x110, out_valid exactly 8 cycles later.
    @(negedge clk);
    in_valid8 = 1'b1;
    command8  = 4'd8;
    a8        = 8'h10;
    b8        = 8'h11;
    #2;
    check("mul8_accept_ready", in_ready8, 1);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      in_valid8 = 1'b0;
      a8        = 8'($urandom);
      b8        = 8'($urandom);
      #2;
      if (k < 8) begin
        check("mul8_early_valid", out_valid8, 0);
        check("mul8_busy_ready", in_ready8, 0);
      end else if (k == 8) begin
        check("mul8_valid", out_valid8, 1);
        check("mul8_value", {result8, carry8, zero8, ovf8}, {8'h10, 1'b1, 1'b0, 1'b0});
      end else begin
        check("mul8_drained", out_valid8, 0);
      end
    end

    // Directed single-cycle cases.
    pin(4'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    pin(4'd1, 32'd5, 32'd5, 32'd0, 1'b1, 1'b1, 1'b0);
    pin(4'd3, 32'h8000_0000, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
    pin(4'd11, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    pin(4'd13, 32'hDEAD_BEEF, 32'h1, 32'd0, 1'b0, 1'b1, 1'b0);
    idle(2);

    // Back-to-back ADD stream with out_ready toggling 1,0,1.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      command   = 4'd0;
      operand_a = 32'(i * 3 + 1);
      operand_b = $urandom;
      out_ready = pat[i % 3][0];
    end
    idle(3);

    // Reset in the middle of a multiply: no result may appear afterwards.
    send(4'd8, $urandom, $urandom);
    idle(3);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle(W + 4);
    pin(4'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      int c;
      @(negedge clk);
      in_valid = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 99) < 4) c = 8;
      else begin
        c = $urandom_range(0, 14);
        if (c >= 8) c++;
      end
      command   = 4'(c);
      operand_a = rand_op();
      operand_b = rand_op();
      out_ready = ($urandom_range(0, 9) < 7);
    end
    idle(W + 5);
    check("drain_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width; legal values 8..64.
REQ-002 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, meaning the operation request is valid.
REQ-005 SHALL have port in_ready, output, 1, meaning the block accepts a request this cycle.
REQ-006 SHALL have port command, input, 4, the opcode.
REQ-007 SHALL have ports operandA and operandB, input, WIDTH each, the operands.
REQ-008 SHALL have port out_valid, output, 1, meaning result and flags are valid.
REQ-009 SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-010 SHALL have port result, output, WIDTH, the registered result.
REQ-011 SHALL have ports carryout, zero and overflow, output, 1 each, the registered flags.

Function
REQ-012 SHALL decode the opcodes ADD=0, SUB=1, XOR=2, SLT=3, AND=4, NAND=5, NOR=6, OR=7, MUL=8, SLL=9, SRL=10, SRA=11; 12..15 reserved.
REQ-013 SHALL treat a request as accepted on a rising edge where in_valid and in_ready are both 1.
REQ-014 SHALL drive in_ready = (state==IDLE) and (out_valid==0 or out_ready==1).
REQ-015 SHALL, for opcodes 0-7 and 9-15, register result and flags on the accept edge, so out_valid rises one cycle after acceptance.
REQ-016 SHALL support a full-throughput single-cycle stream: back-to-back accepts with out_ready=1 give out_valid on every cycle.
REQ-017 SHALL compute ADD/SUB modulo 2^WIDTH. carryout is the MSB carry; SUB carryout is 1 when no borrow occurs. overflow is signed overflow.
REQ-018 SHALL compute SLT as a signed compare: result = 1 if A<B else 0, correct even when A-B overflows.
REQ-019 SHALL compute SLL/SRL/SRA using shift amount operandB[clog2(WIDTH)-1:0]; SRA replicates operandA MSB.
REQ-020 SHALL compute MUL as an unsigned shift-add over WIDTH iterations, with one iteration per cycle.
REQ-021 SHALL give MUL result = low WIDTH bits of the product, carryout = 1 if the high WIDTH bits are nonzero, and overflow = 0.
REQ-022 SHALL produce result 0 with all flags 0 for reserved opcodes.
REQ-023 SHALL drive carryout and overflow to 0 for all ops except ADD, SUB and MUL.
REQ-024 SHALL assert zero when the registered result is all zeros, for every opcode.
REQ-025 SHALL use FSM states IDLE and MUL with these transitions:
- IDLE -> MUL on a MUL accept.
- MUL -> IDLE after WIDTH iteration cycles, loading result/flags and setting out_valid on that final edge (latency WIDTH cycles after acceptance).
REQ-026 SHALL hold in_ready at 0 throughout the MUL state.
REQ-027 SHALL hold result and flags stable while out_valid=1 and out_ready=0.
REQ-028 SHALL clear out_valid on an edge with out_ready=1 unless a new result loads on that same edge.
REQ-029 SHALL not depend on command or operands while in_ready=0 or in_valid=0.

Reset
REQ-030 SHALL, on reset, immediately set state IDLE and clear out_valid, result, carryout, zero, overflow and MUL working registers to 0.
REQ-031 SHALL, on reset asserted mid-MUL, abort the operation with no out_valid pulse after reset release.
REQ-032 SHALL assert in_ready on the first cycle after reset deasserts, provided out_ready is don't-care.

Structure
REQ-033 SHALL place opcode constants and the WIDTH-independent command type in shared package alu_pkg.
REQ-034 SHALL implement the iterative multiplier as sub-module seq_alu_mul, with start/done handshake and parameter WIDTH.
REQ-035 SHALL keep single-cycle datapath logic in seq_alu, using no latches.

Verification
REQ-036 WIDTH=32, ADD A=0x7FFFFFFF B=1 -> result 0x80000000, overflow=1, carryout=0, zero=0, out_valid one cycle after accept.
REQ-037 WIDTH=32, SUB A=5 B=5 -> result 0, zero=1, carryout=1; SLT A=0x80000000 B=1 -> result 1.
REQ-038 WIDTH=8, MUL A=0x10 B=0x11 -> result 0x10, carryout=1; out_valid exactly 8 cycles after accept; in_ready=0 throughout.
REQ-039 Back-to-back ADD stream with out_ready toggling 1,0,1 -> result held during stall, no lost or duplicated results, in_ready=0 while stalled.
REQ-040 Reset pulse at cycle 3 of a WIDTH=32 MUL -> all outputs 0 immediately; no out_valid afterward; next ADD 2+3 gives result 5.
REQ-041 WIDTH=32, SRA A=0x80000000 B=31 -> result 0xFFFFFFFF; reserved opcode 13 -> result 0, zero=1.
